wb4_sync_fifo_gearbox: RTL
==========================

# wb4_sync_fifo_gearbox

Wishbone B4 (pipelined) synchronous FIFO with a parametrised width gearbox: packs R narrow input beats into one wide output word, unpacks one wide input word into R narrow output beats, or passes through at R=1. Successor to the fixed many-to-one FIFO in the library. Sits between two WB4 pipelined master/slave domains on one clock, e.g. byte stream to 32-bit bus.

## Interface
Parameters:
- P_DATA_I_W, 8: input data width.
- P_DATA_O_W, 32: output data width; max(I,O)/min(I,O) = R, a power of two ≥ 1.
- P_DEPTH, 64: storage entries of width L_W = max(I,O); power of two ≥ 2.
- P_AFULL, P_DEPTH-4: almost-full threshold in entries (level ≥ P_AFULL).

Ports:
- i_clk  in  1  clock, all logic on rising edge.
- i_rst_n  in  1  reset, synchronous, active-low.
- i_wb4_in_scyc  in  1  write cycle.
- i_wb4_in_sstb  in  1  write strobe.
- i_wb4_in_sdata  in  P_DATA_I_W  write data.
- o_wb4_in_sack  out  1  write acknowledge.
- o_wb4_in_sstall  out  1  write stall.
- i_wb4_out_scyc  in  1  read cycle.
- i_wb4_out_sstb  in  1  read strobe.
- o_wb4_out_sdata  out  P_DATA_O_W  read data, valid with ack.
- o_wb4_out_sack  out  1  read acknowledge.
- o_wb4_out_sstall  out  1  read stall (no data).
- o_level  out  clog2(P_DEPTH)+1  stored entries (macro only).
- o_afull  out  1  almost full (macro only).

## Operation
- Write accept: cyc & stb & ~stall. Read accept: cyc & stb & ~stall. Stb without cyc ignored.
- Entry count r_count (clog2(P_DEPTH)+1 bits), push/pop pointers clog2(P_DEPTH) bits, wrap naturally modulo P_DEPTH.
- Pack mode (I<O): input lane index 0..R-1; beat k written into bits [k*I +: I] (lane 0 = LSBs). On accepted beat with lane R-1, assembled word pushed; lane index returns to 0. Write stall = (r_count == P_DEPTH) & (lane == R-1); earlier lanes always accepted into pack register.
- Unpack mode (I>O): each accepted input word pushed whole; write stall = (r_count == P_DEPTH). Read side emits head word lane 0..R-1 (LSBs first); entry popped on lane R-1.
- R=1: plain FIFO.
- Read stall = (r_count == 0). No write-to-read bypass.
- Simultaneous push and pop: r_count unchanged. Pop frees space only from the next cycle (stall uses registered count).
- Partial pack word and unpack lane index persist across cyc deassertion; only reset clears them.
- Reset (mid-operation included): pointers, count, lane indices, pack register cleared; all contents discarded.

## Timing
- Reset values: o_wb4_in_sack 0, o_wb4_out_sack 0, o_wb4_out_sdata 0, o_wb4_in_sstall 0, o_wb4_out_sstall 1, o_level 0, o_afull 0.
- Ack: registered, asserted exactly one cycle after each accepted strobe, one ack per accept; back-to-back accepts give continuous ack.
- o_wb4_out_sdata registered, updated only on read accept, held otherwise.
- Push at edge t → read stall low from cycle t+1; first read data and ack at t+2.
- Full throughput: one input beat and one output beat per cycle when neither side stalls.
- Stalls are combinational from registered state only (no input-to-stall path).

## Configuration
- WB4_FIFO_LEVEL_EN defined: o_level = r_count, o_afull = (r_count ≥ P_AFULL), both registered-state derived, ports present.
- Undefined: o_level and o_afull ports and their logic absent; FIFO behaviour otherwise identical.

## Structure
- Shared package wb4_fifo_pkg: lane/ratio helper functions (ratio, max width, log2 depth), count width constant, mode encoding (PACK, UNPACK, PASS).
- One sub-module wb4_fifo_mem: simple dual-port L_W × P_DEPTH array, synchronous write, asynchronous read at pop pointer; gearbox and control in top.

## Test plan
- Pack 8→32, write 0x11,0x22,0x33,0x44 → one entry; read returns 0x44332211 two cycles after 4th accept, write acks 1 cycle after each beat.
- Unpack 32→8, write 0xA1B2C3D4 → four reads return 0xD4,0xC3,0xB2,0xA1; read stall high after 4th accept.
- Fill P_DEPTH=4, R=1 with 4 words → write stall 1; 5th strobe gets no ack; one read → stall 0 next cycle; data order preserved across pointer wrap (10 words through).
- Simultaneous read and write at count=2 for 20 cycles → count stays 2, no lost/duplicated words.
- Pack 8→32: write 2 beats, drop cyc 5 cycles, write 2 more → one word 0xDDCCBBAA; reset with 3 beats pending → read stall stays 1, next 4 beats form clean word.
- With WB4_FIFO_LEVEL_EN, P_DEPTH=8, P_AFULL=6: o_afull rises the cycle after 6th push, o_level tracks pushes/pops exactly.

Source files
------------

// File: rtl/wb4_fifo_pkg.sv
// Shared helpers for the WB4 gearbox FIFO: width/ratio arithmetic, count width
// and the gearbox mode encoding.
package wb4_fifo_pkg;

   typedef enum logic [1:0] {
      MODE_PASS   = 2'd0,
      MODE_PACK   = 2'd1,
      MODE_UNPACK = 2'd2
   } wb4_mode_e;

   function automatic int unsigned f_max_w(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

   function automatic int unsigned f_min_w(input int unsigned a, input int unsigned b);
      return (a < b) ? a : b;
   endfunction

   // Number of narrow lanes per wide word.
   function automatic int unsigned f_ratio(input int unsigned a, input int unsigned b);
      return f_max_w(a, b) / f_min_w(a, b);
   endfunction

   // Ceiling log2, never below 1 so that index vectors stay at least one bit wide.
   function automatic int unsigned f_log2(input int unsigned n);
      for (int unsigned i = 1; i < 32; i++) begin
         if ((32'd1 << i) >= n) return i;
      end
      return 32;
   endfunction

   // Entry counter needs one extra bit to represent "full".
   function automatic int unsigned f_cnt_w(input int unsigned depth);
      return f_log2(depth) + 1;
   endfunction

   function automatic wb4_mode_e f_mode(input int unsigned in_w, input int unsigned out_w);
      if (in_w < out_w) return MODE_PACK;
      if (in_w > out_w) return MODE_UNPACK;
      return MODE_PASS;
   endfunction

endpackage

// File: rtl/wb4_fifo_mem.sv
// Simple dual-port storage: synchronous write, asynchronous read.
// Contents are never reset; the owning FIFO discards them by clearing pointers.
module wb4_fifo_mem #(
   parameter int unsigned P_W     = 32,
   parameter int unsigned P_DEPTH = 64,
   parameter int unsigned P_AW    = 6
) (
   input  logic            i_clk,
   input  logic            i_we,
   input  logic [P_AW-1:0] i_waddr,
   input  logic [P_W-1:0]  i_wdata,
   input  logic [P_AW-1:0] i_raddr,
   output logic [P_W-1:0]  o_rdata
);

   logic [P_W-1:0] r_mem [P_DEPTH];

   // Write port.
   always_ff @(posedge i_clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/wb4_sync_fifo_gearbox.sv
// WB4 pipelined synchronous FIFO with a width gearbox.
// Packs narrow beats into wide entries (I<O), unpacks wide entries into narrow
// beats (I>O) or passes through (I==O). Storage width is max(I,O).
// Optional feature macro: WB4_FIFO_LEVEL_EN adds o_level / o_afull.
module wb4_sync_fifo_gearbox
   import wb4_fifo_pkg::*;
#(
   parameter int unsigned P_DATA_I_W = 8,
   parameter int unsigned P_DATA_O_W = 32,
   parameter int unsigned P_DEPTH    = 64,
   parameter int unsigned P_AFULL    = P_DEPTH - 4
) (
   input  logic                            i_clk,
   input  logic                            i_rst_n,
   input  logic                            i_wb4_in_scyc,
   input  logic                            i_wb4_in_sstb,
   input  logic [P_DATA_I_W-1:0]           i_wb4_in_sdata,
   output logic                            o_wb4_in_sack,
   output logic                            o_wb4_in_sstall,
   input  logic                            i_wb4_out_scyc,
   input  logic                            i_wb4_out_sstb,
   output logic [P_DATA_O_W-1:0]           o_wb4_out_sdata,
   output logic                            o_wb4_out_sack,
`ifdef WB4_FIFO_LEVEL_EN
   output logic                            o_wb4_out_sstall,
   output logic [f_cnt_w(P_DEPTH)-1:0]     o_level,
   output logic                            o_afull
`else
   output logic                            o_wb4_out_sstall
`endif
);

   localparam int unsigned L_W    = f_max_w(P_DATA_I_W, P_DATA_O_W);
   localparam int unsigned L_R    = f_ratio(P_DATA_I_W, P_DATA_O_W);
   localparam wb4_mode_e   L_MODE = f_mode(P_DATA_I_W, P_DATA_O_W);
   localparam int unsigned L_AW   = f_log2(P_DEPTH);
   localparam int unsigned L_CW   = f_cnt_w(P_DEPTH);
   localparam int unsigned L_LW   = f_log2(L_R);

   localparam logic [L_CW-1:0] L_FULL      = L_CW'(P_DEPTH);
   localparam logic [L_LW-1:0] L_LANE_LAST = L_LW'(L_R - 1);

   logic [L_AW-1:0]       r_wptr;
   logic [L_AW-1:0]       r_rptr;
   logic [L_CW-1:0]       r_count;
   logic                  r_in_ack;
   logic                  r_out_ack;
   logic [P_DATA_O_W-1:0] r_out_data;

   logic                  w_full;
   logic                  w_empty;
   logic                  w_in_stall;
   logic                  w_out_stall;
   logic                  w_wr_acc;
   logic                  w_rd_acc;
   logic                  w_push;
   logic                  w_pop;
   logic [L_W-1:0]        w_push_data;
   logic [L_W-1:0]        w_head;
   logic [P_DATA_O_W-1:0] w_rd_data;

   assign w_full      = (r_count == L_FULL);
   assign w_empty     = (r_count == '0);
   assign w_out_stall = w_empty;
   assign w_wr_acc    = i_wb4_in_scyc & i_wb4_in_sstb & ~w_in_stall;
   assign w_rd_acc    = i_wb4_out_scyc & i_wb4_out_sstb & ~w_out_stall;

   generate
      if (L_MODE == MODE_PACK) begin : g_pack
         logic [L_LW-1:0] r_in_lane;
         logic [L_W-1:0]  r_pack;
         logic [L_W-1:0]  w_pack_word;
         logic            w_in_last;

         assign w_in_last = (r_in_lane == L_LANE_LAST);
         // Earlier lanes only touch the pack register, so they never stall.
         assign w_in_stall = w_full & w_in_last;
         assign w_push     = w_wr_acc & w_in_last;
         assign w_push_data = w_pack_word;
         assign w_pop      = w_rd_acc;
         assign w_rd_data  = w_head;

         // Merge the incoming beat into its lane of the partial word.
         always_comb begin
            w_pack_word = r_pack;
            w_pack_word[r_in_lane*P_DATA_I_W +: P_DATA_I_W] = i_wb4_in_sdata;
         end

         // Lane index and partial word survive cyc drops; only reset clears them.
         always_ff @(posedge i_clk) begin
            if (!i_rst_n) begin
               r_in_lane <= '0;
               r_pack    <= '0;
            end else if (w_wr_acc) begin
               r_in_lane <= r_in_lane + L_LW'(1);
               r_pack    <= w_pack_word;
            end
         end
      end else if (L_MODE == MODE_UNPACK) begin : g_unpack
         logic [L_LW-1:0] r_out_lane;
         logic            w_out_last;

         assign w_out_last  = (r_out_lane == L_LANE_LAST);
         assign w_in_stall  = w_full;
         assign w_push      = w_wr_acc;
         assign w_push_data = i_wb4_in_sdata;
         // Head entry is only retired once its last lane has been read.
         assign w_pop       = w_rd_acc & w_out_last;
         assign w_rd_data   = w_head[r_out_lane*P_DATA_O_W +: P_DATA_O_W];

         // Read lane index, LSB lane first.
         always_ff @(posedge i_clk) begin
            if (!i_rst_n) begin
               r_out_lane <= '0;
            end else if (w_rd_acc) begin
               r_out_lane <= r_out_lane + L_LW'(1);
            end
         end
      end else begin : g_pass
         assign w_in_stall  = w_full;
         assign w_push      = w_wr_acc;
         assign w_push_data = i_wb4_in_sdata;
         assign w_pop       = w_rd_acc;
         assign w_rd_data   = w_head;
      end
   endgenerate

   wb4_fifo_mem #(
      .P_W     (L_W),
      .P_DEPTH (P_DEPTH),
      .P_AW    (L_AW)
   ) u_mem (
      .i_clk   (i_clk),
      .i_we    (w_push),
      .i_waddr (r_wptr),
      .i_wdata (w_push_data),
      .i_raddr (r_rptr),
      .o_rdata (w_head)
   );

   // Pointers, occupancy, acks and registered read data.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_count    <= '0;
         r_in_ack   <= 1'b0;
         r_out_ack  <= 1'b0;
         r_out_data <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + L_AW'(1);
         if (w_pop)  r_rptr <= r_rptr + L_AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + L_CW'(1);
            2'b01:   r_count <= r_count - L_CW'(1);
            default: r_count <= r_count;
         endcase
         r_in_ack  <= w_wr_acc;
         r_out_ack <= w_rd_acc;
         if (w_rd_acc) r_out_data <= w_rd_data;
      end
   end

   assign o_wb4_in_sack    = r_in_ack;
   assign o_wb4_in_sstall  = w_in_stall;
   assign o_wb4_out_sack   = r_out_ack;
   assign o_wb4_out_sstall = w_out_stall;
   assign o_wb4_out_sdata  = r_out_data;

`ifdef WB4_FIFO_LEVEL_EN
   assign o_level = r_count;
   assign o_afull = (r_count >= L_CW'(P_AFULL));
`endif

endmodule
